// File: rtl/posit_multiply_seq.sv
// Iterative radix-2 shift-add posit multiplier producing an unrounded unpacked product plus guard/sticky bits.
// Define POSIT_MUL_EARLY_TERM_EN to stop the multiply loop once the remaining multiplier bits are all zero.
module posit_multiply_seq #(
    parameter int WIDTH         = 8,
    parameter int ES            = 1,
    parameter int TRAILING_BITS = 2,
    localparam int FB           = WIDTH - 2 - ES,
    localparam int MAX_EXP      = (WIDTH - 2) << ES,
    localparam int EW           = $clog2(MAX_EXP + 1) + 1,
    localparam int UW           = 3 + EW + FB
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [UW-1:0]            a_i,
    input  logic [UW-1:0]            b_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [UW-1:0]            out_o,
    output logic [TRAILING_BITS-1:0] trailing_bits_o,
    output logic                     sticky_bit_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);
    localparam int CW = $clog2(FB + 2);
    localparam logic [CW-1:0]        CNT_LAST = CW'(FB);
    localparam logic [CW-1:0]        CNT_END  = CW'(FB + 1);
    localparam logic signed [EW+1:0] EXP_HI   = (EW + 2)'(MAX_EXP);
    localparam logic signed [EW+1:0] EXP_LO   = -EXP_HI;

    typedef struct packed {
        logic          is_inf;
        logic          is_zero;
        logic          sign;
        logic [EW-1:0] exponent;
        logic [FB-1:0] fraction;
    } unpacked_t;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_e;

    state_e                    state_q, state_d;
    unpacked_t                 a_s, b_s, out_q, out_d;
    logic                      sign_q, sign_d;
    logic signed [EW+1:0]      exp_sum_q, exp_sum_d;
    logic [FB:0]               mcand_q, mcand_d, mplier_q, mplier_d;
    logic [2*FB+1:0]           acc_q, acc_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TRAILING_BITS-1:0]  trail_q, trail_d;
    logic                      sticky_q, sticky_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept, special, mul_last;
    logic [2*FB+1:0]           prod, norm;
    logic signed [EW+1:0]      exp_n;
    logic [FB+TRAILING_BITS:0] tail;

    assign a_s     = a_i;
    assign b_s     = b_i;
    assign accept  = in_valid_i && (state_q == IDLE);
    assign special = a_s.is_inf || b_s.is_inf || a_s.is_zero || b_s.is_zero;
`ifdef POSIT_MUL_EARLY_TERM_EN
    assign mul_last = (cnt_q == CNT_LAST) || (mplier_q[FB-1:0] == '0);
`else
    assign mul_last = (cnt_q == CNT_LAST);
`endif

    // NOTE: sequential state uses non-blocking assignments only; the comb blocks compute every _d value.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            out_q       <= '{is_inf: 1'b0, is_zero: 1'b1, sign: 1'b0, exponent: '0, fraction: '0};
            trail_q     <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            trail_q     <= trail_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
        end
        // NOTE: pure datapath registers skip reset; they are always reloaded on accept before use.
        sign_q    <= sign_d;
        exp_sum_q <= exp_sum_d;
        mcand_q   <= mcand_d;
        mplier_q  <= mplier_d;
        acc_q     <= acc_d;
        cnt_q     <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : MUL;
            MUL:  if (mul_last) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (out_valid_q && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Normalisation view of the accumulator; the early build first applies the skipped shifts.
    always_comb begin
        prod = acc_q;
`ifdef POSIT_MUL_EARLY_TERM_EN
        prod = acc_q << (CNT_END - cnt_q);
`endif
        norm  = prod[2*FB+1] ? prod : (prod << 1);
        exp_n = exp_sum_q + $signed({{(EW + 1){1'b0}}, prod[2*FB+1]});
        tail  = {norm[FB:0], {TRAILING_BITS{1'b0}}};
    end

    always_comb begin
        sign_d      = sign_q;
        exp_sum_d   = exp_sum_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        trail_d     = trail_q;
        sticky_d    = sticky_q;
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready_i);
        unique case (state_q)
            IDLE: if (accept) begin
                sign_d    = a_s.sign ^ b_s.sign;
                exp_sum_d = $signed({{2{a_s.exponent[EW-1]}}, a_s.exponent})
                          + $signed({{2{b_s.exponent[EW-1]}}, b_s.exponent});
                mcand_d   = {1'b1, a_s.fraction};
                mplier_d  = {1'b1, b_s.fraction};
                acc_d     = '0;
                cnt_d     = '0;
                if (special) begin
                    out_d    = '{is_inf: 1'b0, is_zero: 1'b1, sign: 1'b0, exponent: '0, fraction: '0};
                    // Infinity dominates, so inf*0 yields NaR rather than zero.
                    if (a_s.is_inf || b_s.is_inf) begin
                        out_d.is_inf  = 1'b1;
                        out_d.is_zero = 1'b0;
                    end
                    trail_d  = '0;
                    sticky_d = 1'b0;
                end
            end
            MUL: begin
                acc_d    = (acc_q << 1) + (mplier_q[FB] ? {{(FB + 1){1'b0}}, mcand_q} : '0);
                mplier_d = mplier_q << 1;
                cnt_d    = cnt_q + CW'(1);
            end
            NORM: begin
                out_d.is_inf  = 1'b0;
                out_d.is_zero = 1'b0;
                out_d.sign    = sign_q;
                if (exp_n > EXP_HI || exp_n < EXP_LO) begin
                    out_d.exponent = (exp_n > EXP_HI) ? EXP_HI[EW-1:0] : EXP_LO[EW-1:0];
                    out_d.fraction = '0;
                    trail_d        = '0;
                    sticky_d       = 1'b0;
                end else begin
                    out_d.exponent = exp_n[EW-1:0];
                    out_d.fraction = norm[2*FB:FB+1];
                    trail_d        = tail[FB+TRAILING_BITS:FB+1];
                    sticky_d       = |tail[FB:0];
                end
            end
            default: ;
        endcase
    end

    assign in_ready_o      = (state_q == IDLE);
    assign out_valid_o     = out_valid_q;
    assign out_o           = out_q;
    assign trailing_bits_o = trail_q;
    assign sticky_bit_o    = sticky_q;
endmodule

// File: tb/tb_posit_multiply_seq.sv
// Self-checking bench for posit_multiply_seq (WIDTH=8, ES=1): vector table, corner sequences and random ops
// against an arithmetic reference model; latency expectations follow POSIT_MUL_EARLY_TERM_EN when defined.
module tb_posit_multiply_seq;
    localparam int WIDTH = 8;
    localparam int ES    = 1;
    localparam int TB    = 2;
    localparam int FB    = WIDTH - 2 - ES;
    localparam int MAXE  = (WIDTH - 2) << ES;
    localparam int EW    = $clog2(MAXE + 1) + 1;
    localparam int UW    = 3 + EW + FB;
    localparam int BUDGET = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [UW-1:0] a_v = '0, b_v = '0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, out_valid, sticky;
    logic [UW-1:0] out_v;
    logic [TB-1:0] trail;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit inf, zero, sign;
        int exp, frac, trail, sticky;
    } res_t;

    typedef struct {
        logic [7:0] a, b;
        res_t       r;
    } vec_t;

    posit_multiply_seq #(.WIDTH(WIDTH), .ES(ES), .TRAILING_BITS(TB)) dut (
        .clock_i(clk), .reset_i(reset), .a_i(a_v), .b_i(b_v), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .out_o(out_v), .trailing_bits_o(trail), .sticky_bit_o(sticky),
        .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Posit8 byte -> unpacked {inf, zero, sign, exponent, fraction}.
    function automatic logic [UW-1:0] decode(input logic [7:0] p);
        logic [7:0] v;
        int m, k, pos, e, f;
        if (p == 8'h00) return {1'b0, 1'b1, 1'b0, {(EW + FB){1'b0}}};
        if (p == 8'h80) return {1'b1, 1'b0, 1'b0, {(EW + FB){1'b0}}};
        v = p[7] ? 8'(-p) : p;
        m = 0;
        while (m < 7 && v[6 - m] == v[6]) m++;
        k = v[6] ? m - 1 : -m;
        pos = 6 - m - 1;
        e = 0;
        if (pos >= 0) begin e = int'(v[pos]); pos--; end
        f = 0;
        if (pos >= 0) f = (int'(v) & ((1 << (pos + 1)) - 1)) << (FB - (pos + 1));
        return {1'b0, 1'b0, p[7], EW'(2 * k + e), FB'(f)};
    endfunction

    function automatic res_t model(input logic [7:0] pa, input logic [7:0] pb);
        logic [UW-1:0] ua, ub;
        res_t r;
        int p, q, low, ex;
        ua = decode(pa);
        ub = decode(pb);
        r = '{inf: 0, zero: 0, sign: 0, exp: 0, frac: 0, trail: 0, sticky: 0};
        if (ua[UW-1] || ub[UW-1]) begin r.inf = 1; return r; end
        if (ua[UW-2] || ub[UW-2]) begin r.zero = 1; return r; end
        r.sign = ua[UW-3] ^ ub[UW-3];
        ex = int'($signed(ua[FB+EW-1:FB])) + int'($signed(ub[FB+EW-1:FB]));
        p  = ((1 << FB) + int'(ua[FB-1:0])) * ((1 << FB) + int'(ub[FB-1:0]));
        // Product of two values in [1,2) lies in [1,4); rescale to [1,2) with 2FB+1 fraction bits.
        if (p >= (1 << (2 * FB + 1))) begin ex++; q = p; end
        else q = 2 * p;
        low      = q - (1 << (2 * FB + 1));
        r.frac   = low / (1 << (FB + 1));
        r.trail  = (low / (1 << (FB + 1 - TB))) % (1 << TB);
        r.sticky = (low % (1 << (FB + 1 - TB))) != 0;
        r.exp    = ex;
        if (ex > MAXE || ex < -MAXE) begin
            r.exp = (ex > MAXE) ? MAXE : -MAXE;
            r.frac = 0; r.trail = 0; r.sticky = 0;
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [7:0] pa, input logic [7:0] pb);
        logic [UW-1:0] ua, ub;
        int mb, tz;
        ua = decode(pa);
        ub = decode(pb);
        if (ua[UW-1] || ub[UW-1] || ua[UW-2] || ub[UW-2]) return 1;
`ifdef POSIT_MUL_EARLY_TERM_EN
        mb = (1 << FB) + int'(ub[FB-1:0]);
        tz = 0;
        while (((mb >> tz) & 1) == 0) tz++;
        return FB - tz + 3;
`else
        mb = 0; tz = 0;
        return FB + 3;
`endif
    endfunction

    task automatic compare(input string tag, input res_t want);
        check({tag, ".inf"}, int'(out_v[UW-1]), int'(want.inf));
        check({tag, ".zero"}, int'(out_v[UW-2]), int'(want.zero));
        check({tag, ".trail"}, int'(trail), want.trail);
        check({tag, ".sticky"}, int'(sticky), want.sticky);
        if (!want.inf && !want.zero) begin
            check({tag, ".sign"}, int'(out_v[UW-3]), int'(want.sign));
            check({tag, ".exp"}, int'($signed(out_v[FB+EW-1:FB])), want.exp);
            check({tag, ".frac"}, int'(out_v[FB-1:0]), want.frac);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the handshake edge.
    task automatic run_op(input string tag, input logic [7:0] pa, input logic [7:0] pb,
                          input bit early_ready, input res_t want);
        int lat;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        a_v = decode(pa);
        b_v = decode(pb);
        in_valid  = 1'b1;
        out_ready = early_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < BUDGET);
        check({tag, ".latency"}, lat, exp_latency(pa, pb));
        compare(tag, want);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        vec_t tbl[7];
        res_t held;
        logic [UW-1:0] held_v;
        int lat;

        tbl[0] = '{a: 8'h40, b: 8'h40, r: '{0, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{a: 8'h48, b: 8'h48, r: '{0, 0, 0, 1, 4, 0, 0}};
        tbl[2] = '{a: 8'h80, b: 8'h00, r: '{1, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{a: 8'h00, b: 8'h50, r: '{0, 1, 0, 0, 0, 0, 0}};
        tbl[4] = '{a: 8'h7F, b: 8'h7F, r: '{0, 0, 0, 12, 0, 0, 0}};
        tbl[5] = '{a: 8'h01, b: 8'h01, r: '{0, 0, 0, -12, 0, 0, 0}};
        tbl[6] = '{a: 8'hC0, b: 8'h48, r: '{0, 0, 1, 0, 16, 0, 0}};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset.in_ready", int'(in_ready), 1);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.is_zero", int'(out_v[UW-2]), 1);
        check("reset.trail", int'(trail), 0);
        check("reset.sticky", int'(sticky), 0);

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].r);

        // Backpressure: result must hold and new requests must be ignored.
        a_v = decode(8'h48); b_v = decode(8'h48); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < BUDGET);
        check("bp.valid", int'(out_valid), 1);
        held_v = out_v;
        held = model(8'h48, 8'h48);
        compare("bp", held);
        a_v = decode(8'h40); b_v = decode(8'h40); in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", int'(out_valid), 1);
            check("bp.hold_ready", int'(in_ready), 0);
            check("bp.hold_out", int'(out_v), int'(held_v));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release_valid", int'(out_valid), 0);
        check("bp.release_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp.idle_ready", int'(in_ready), 1);
        check("bp.idle_valid", int'(out_valid), 0);

        // Reset in the third MUL cycle abandons the operation.
        a_v = decode(8'h4F); b_v = decode(8'h4F); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.is_zero", int'(out_v[UW-2]), 1);
        reset = 1'b0;
        run_op("post_rst", 8'h48, 8'h48, 1'b0, model(8'h48, 8'h48));

        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op($sformatf("rnd%0d_%02h_%02h", i, ra, rb), ra, rb, 1'($urandom), model(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
